// File: rtl/uart_pkt_mstr.sv
// uart_pkt_mstr -- UART command/response master with built-in 8N1 engines.
// A CMD_BYTES-wide command is latched in one handshake and sent MSB-byte
// first; RESP_BYTES received bytes are assembled into o_resp, first byte in
// the MSBs. Bytes with a bad stop bit are dropped and flagged on o_frm_err.
// Optional feature macro: UART_PKT_RESP_TIMEOUT_EN builds a response-window
// timer that raises o_resp_timeout if no full response follows a command.
module uart_pkt_mstr #(
  parameter int CMD_BYTES         = 2,
  parameter int RESP_BYTES        = 1,
  parameter int CLKS_PER_BIT      = 2604,
  parameter int RESP_TIMEOUT_CLKS = 1000000
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_send_cmd,
  input  logic [8*CMD_BYTES-1:0]  i_cmd,
  output logic                    o_tx,
  input  logic                    i_rx,
  output logic                    o_busy,
  output logic                    o_cmd_sent,
  output logic [8*RESP_BYTES-1:0] o_resp,
  output logic                    o_resp_rdy,
  input  logic                    i_clr_resp_rdy,
  output logic                    o_frm_err,
  output logic                    o_resp_timeout
);

  localparam int CMDW  = 8*CMD_BYTES;
  localparam int RESPW = 8*RESP_BYTES;
  localparam int CW    = $clog2(CLKS_PER_BIT);

  // Bit-timer terminal counts: full bit and half bit (start-bit centre).
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT-1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT/2-1);
  localparam logic [3:0]    TX_LAST  = 4'(CMD_BYTES-1);
  localparam logic [3:0]    RX_LAST  = 4'(RESP_BYTES-1);

  // Shared state encoding for both serial engines.
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  // ---------------------------------------------------------------- TX side
  logic [1:0]      r_tx_state;
  logic [CW-1:0]   r_tx_cnt;
  logic [2:0]      r_tx_bit;
  logic [3:0]      r_tx_nbytes;
  logic [CMDW-1:0] r_tx_shreg;
  logic [7:0]      r_tx_byte;
  logic            r_tx;
  logic            r_cmd_sent;

  logic w_accept;
  logic w_tx_bit_end;
  logic w_tx_done;

  assign w_accept     = i_send_cmd & (r_tx_state == S_IDLE);
  assign w_tx_bit_end = (r_tx_cnt == BIT_END);
  assign w_tx_done    = (r_tx_state == S_STOP) & w_tx_bit_end & (r_tx_nbytes == TX_LAST);

  // TX engine: the whole command sits in r_tx_shreg, top byte is always next.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tx_state  <= S_IDLE;
      r_tx_cnt    <= '0;
      r_tx_bit    <= '0;
      r_tx_nbytes <= '0;
      r_tx_shreg  <= '0;
      r_tx_byte   <= '0;
      r_tx        <= 1'b1;
    end else begin
      case (r_tx_state)
        S_IDLE: begin
          r_tx <= 1'b1;
          if (w_accept) begin
            r_tx_state  <= S_START;
            r_tx_shreg  <= i_cmd;
            r_tx_cnt    <= '0;
            r_tx_nbytes <= '0;
            r_tx        <= 1'b0;
          end
        end
        S_START: begin
          if (w_tx_bit_end) begin
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_state <= S_DATA;
            r_tx       <= r_tx_shreg[CMDW-8];
            r_tx_byte  <= {1'b0, r_tx_shreg[CMDW-1:CMDW-7]};
          end else begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (w_tx_bit_end) begin
            r_tx_cnt <= '0;
            if (r_tx_bit == 3'd7) begin
              r_tx_state <= S_STOP;
              r_tx       <= 1'b1;
            end else begin
              r_tx_bit  <= r_tx_bit + 1'b1;
              r_tx      <= r_tx_byte[0];
              r_tx_byte <= {1'b0, r_tx_byte[7:1]};
            end
          end else begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
          end
        end
        default: begin
          if (w_tx_bit_end) begin
            r_tx_cnt <= '0;
            if (w_tx_done) begin
              r_tx_state <= S_IDLE;
            end else begin
              // Next byte starts immediately: no idle gap between bytes.
              r_tx_state  <= S_START;
              r_tx_nbytes <= r_tx_nbytes + 1'b1;
              r_tx_shreg  <= r_tx_shreg << 8;
              r_tx        <= 1'b0;
            end
          end else begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  // cmd_sent: set when the last stop bit ends, cleared by the next accept.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)          r_cmd_sent <= 1'b0;
    else if (w_tx_done) r_cmd_sent <= 1'b1;
    else if (w_accept)  r_cmd_sent <= 1'b0;
  end

  assign o_tx       = r_tx;
  assign o_busy     = (r_tx_state != S_IDLE);
  assign o_cmd_sent = r_cmd_sent;

  // ---------------------------------------------------------------- RX side
  logic             r_rx_s1;
  logic             r_rx_s2;
  logic             r_rx_prev;
  logic [1:0]       r_rx_state;
  logic [CW-1:0]    r_rx_cnt;
  logic [2:0]       r_rx_bit;
  logic [7:0]       r_rx_byte;
  logic [RESPW-1:0] r_rx_shreg;
  logic [3:0]       r_rx_nbytes;
  logic [RESPW-1:0] r_resp;
  logic             r_resp_rdy;
  logic             r_frm_err;

  logic             w_stop_smp;
  logic             w_stop_ok;
  logic             w_resp_set;
  logic             w_to_fire;
  logic [RESPW+7:0] w_rx_cat;
  logic [RESPW-1:0] w_rx_next;

  assign w_stop_smp = (r_rx_state == S_STOP) & (r_rx_cnt == BIT_END);
  assign w_stop_ok  = w_stop_smp & r_rx_s2;
  assign w_resp_set = w_stop_ok & (r_rx_nbytes == RX_LAST);
  assign w_rx_cat   = {r_rx_shreg, r_rx_byte};
  assign w_rx_next  = w_rx_cat[RESPW-1:0];

  // Two-flop synchroniser plus a delayed copy for falling-edge detection.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rx_s1   <= 1'b1;
      r_rx_s2   <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_s1   <= i_rx;
      r_rx_s2   <= r_rx_s1;
      r_rx_prev <= r_rx_s2;
    end
  end

  // RX engine: start-bit check at half bit, then samples every full bit.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rx_state <= S_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_byte  <= '0;
    end else begin
      case (r_rx_state)
        S_IDLE: begin
          r_rx_cnt <= '0;
          if (r_rx_prev & ~r_rx_s2) r_rx_state <= S_START;
        end
        S_START: begin
          if (r_rx_cnt == HALF_END) begin
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            // A line already back high is a glitch, not a start bit.
            r_rx_state <= r_rx_s2 ? S_IDLE : S_DATA;
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (r_rx_cnt == BIT_END) begin
            r_rx_cnt  <= '0;
            r_rx_byte <= {r_rx_s2, r_rx_byte[7:1]};
            if (r_rx_bit == 3'd7) r_rx_state <= S_STOP;
            else                  r_rx_bit   <= r_rx_bit + 1'b1;
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        default: begin
          if (w_stop_smp) begin
            r_rx_cnt   <= '0;
            r_rx_state <= S_IDLE;
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  // Response assembly: good bytes shift in, a bad stop bit restarts the count.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rx_shreg  <= '0;
      r_rx_nbytes <= '0;
      r_resp      <= '0;
      r_frm_err   <= 1'b0;
    end else begin
      r_frm_err <= w_stop_smp & ~r_rx_s2;
      if (w_stop_ok)  r_rx_shreg <= w_rx_next;
      if (w_resp_set) r_resp     <= w_rx_next;
      if (w_accept | w_to_fire)             r_rx_nbytes <= '0;
      else if (w_stop_smp & ~r_rx_s2)       r_rx_nbytes <= '0;
      else if (w_resp_set)                  r_rx_nbytes <= '0;
      else if (w_stop_ok)                   r_rx_nbytes <= r_rx_nbytes + 1'b1;
    end
  end

  // resp_rdy: a completing response beats a same-cycle clear.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                            r_resp_rdy <= 1'b0;
    else if (w_resp_set)                  r_resp_rdy <= 1'b1;
    else if (i_clr_resp_rdy | w_accept)   r_resp_rdy <= 1'b0;
  end

  assign o_resp     = r_resp;
  assign o_resp_rdy = r_resp_rdy;
  assign o_frm_err  = r_frm_err;

  // ----------------------------------------------------------- Resp timeout
`ifdef UART_PKT_RESP_TIMEOUT_EN
  localparam int TW = $clog2(RESP_TIMEOUT_CLKS+1);
  localparam logic [TW-1:0] TO_END = TW'(RESP_TIMEOUT_CLKS-1);

  logic          r_to_run;
  logic [TW-1:0] r_to_cnt;
  logic          r_to;

  assign w_to_fire = r_to_run & (r_to_cnt == TO_END) & ~w_resp_set;

  // Window opens when the command finishes and closes on a full response.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_to_run <= 1'b0;
      r_to_cnt <= '0;
      r_to     <= 1'b0;
    end else if (w_accept) begin
      r_to_run <= 1'b0;
      r_to_cnt <= '0;
      r_to     <= 1'b0;
    end else if (w_tx_done) begin
      r_to_run <= 1'b1;
      r_to_cnt <= '0;
    end else if (w_resp_set) begin
      r_to_run <= 1'b0;
    end else if (w_to_fire) begin
      r_to_run <= 1'b0;
      r_to     <= 1'b1;
    end else if (r_to_run) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  assign o_resp_timeout = r_to;
`else
  assign w_to_fire      = 1'b0;
  assign o_resp_timeout = 1'b0;
`endif

endmodule
